exc_commit_ctrl: RTL and testbench

Exception/interrupt commit controller at the writeback/commit stage, on the write side of the CP0 exception-update interface. Prioritises exception flags of the committing instruction and pending CP0 interrupts. Produces a one-cycle CP0 update pulse (or an EXL-clear pulse on ERET), then a timed pipeline flush, then a valid/ready redirect handshake towards fetch.

---
 rtl/exc_commit_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_exc_commit_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_commit_ctrl.sv
// ----------------------------------------------------------------------------
// exc_commit_ctrl
//
// Exception / interrupt commit controller at the writeback stage. It drives
// the write side of the CP0 exception-update interface.
//
// When an instruction commits while the controller is idle, it ranks the
// instruction's exception flags together with any pending CP0 interrupt.
// A trigger then produces:
//   - a one-cycle CP0 update pulse, or an EXL-clear pulse for ERET;
//   - a pipeline flush held for FLUSH_CYCLES cycles;
//   - a valid/ready redirect request towards fetch.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   commit_*            committing instruction: valid, PC, delay-slot bit,
//                       exception flags, ERET, data address
//   commit_ready        high only while idle; upstream holds otherwise
//   cp0_has_int         pending enabled interrupt
//   cp0_epc             current EPC; this is the ERET return target
//   w_cp0_*             exception update towards CP0; the data fields hold
//                       their value whenever the enables are low
//   cp0_cls_exl         one-cycle Status.EXL clear on ERET
//   flush               squash all younger stages
//   redirect_valid/pc   redirect request to fetch; redirect_ready accepts it
// ----------------------------------------------------------------------------
module exc_commit_ctrl #(
    parameter logic [31:0] EXC_VEC      = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [31:0] commit_pc,
    input  logic        commit_in_ds,
    input  logic        commit_adel_if,
    input  logic        commit_ri,
    input  logic        commit_ov,
    input  logic        commit_syscall,
    input  logic        commit_break,
    input  logic        commit_adel_ld,
    input  logic        commit_ades,
    input  logic        commit_eret,
    input  logic [31:0] commit_mem_addr,
    input  logic        cp0_has_int,
    input  logic [31:0] cp0_epc,
    output logic        w_cp0_update_ena,
    output logic [4:0]  w_cp0_exccode,
    output logic        w_cp0_bd,
    output logic        w_cp0_exl,
    output logic [31:0] w_cp0_epc,
    output logic        w_cp0_badvaddr_ena,
    output logic [31:0] w_cp0_badvaddr,
    output logic        cp0_cls_exl,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    // The counter holds the number of flush cycles still to follow the
    // current one, so it is loaded with FLUSH_CYCLES-1.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    // ExcCode per flag position. Position 0 has the highest priority.
    // Order: Int, AdEL-fetch, RI, Ov, Sys, Bp, AdEL-load, AdES.
    localparam logic [39:0] EXC_CODES = {5'h05, 5'h04, 5'h09, 5'h08,
                                         5'h0C, 5'h0A, 5'h04, 5'h00};

    state_t      state_reg, state_next;
    logic [3:0]  flush_cnt_reg, flush_cnt_next;

    logic [7:0]  exc_flags;
    logic [7:0]  exc_grant;
    logic [39:0] code_terms;
    logic [4:0]  exc_code;
    logic        any_exc;
    logic        trigger;
    logic        exc_take;
    logic        eret_take;
    logic        badvaddr_sel;
    logic [31:0] badvaddr_val;
    logic [31:0] epc_val;

    logic        update_ena_reg;
    logic [4:0]  exccode_reg;
    logic        bd_reg;
    logic        exl_reg;
    logic [31:0] epc_reg;
    logic        badvaddr_ena_reg;
    logic [31:0] badvaddr_reg;
    logic        cls_exl_reg;
    logic [31:0] redirect_pc_reg;

    assign exc_flags = {commit_ades, commit_adel_ld, commit_break, commit_syscall,
                        commit_ov, commit_ri, commit_adel_if, cp0_has_int};

    // One-hot grant: a flag wins only when no flag at a lower index is set.
    // Each granted position contributes its ExcCode, and the terms are then
    // OR-reduced.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_prio
            if (gi == 0) begin : g_top
                assign exc_grant[gi] = exc_flags[gi];
            end else begin : g_rest
                assign exc_grant[gi] = exc_flags[gi] & ~(|exc_flags[gi-1:0]);
            end
            assign code_terms[gi*5 +: 5] = exc_grant[gi] ? EXC_CODES[gi*5 +: 5] : 5'h00;
        end
    endgenerate

    always_comb begin
        exc_code = 5'h00;
        for (int i = 0; i < 8; i++) begin
            exc_code = exc_code | code_terms[i*5 +: 5];
        end
    end

    assign any_exc      = |exc_flags;
    assign trigger      = (state_reg == ST_IDLE) & commit_valid & (any_exc | commit_eret);
    assign exc_take     = trigger & any_exc;
    // ERET is overridden by any interrupt or exception on the same commit.
    assign eret_take    = trigger & ~any_exc & commit_eret;
    assign badvaddr_sel = exc_grant[1] | exc_grant[6] | exc_grant[7];
    assign badvaddr_val = exc_grant[1] ? commit_pc : commit_mem_addr;
    // A delay-slot instruction restarts at its branch. The subtraction wraps
    // modulo 2^32.
    assign epc_val      = commit_in_ds ? (commit_pc - 32'd4) : commit_pc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            flush_cnt_reg <= 4'd0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (trigger) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_reg == 4'd0) begin
                    state_next = ST_REDIRECT;
                end else begin
                    flush_cnt_next = flush_cnt_reg - 4'd1;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                flush_cnt_next = 4'd0;
            end
        endcase
    end

    // CP0 update and redirect-target registers. The pulses last one cycle.
    // The data fields change only when their pulse fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            update_ena_reg   <= 1'b0;
            exccode_reg      <= 5'h00;
            bd_reg           <= 1'b0;
            exl_reg          <= 1'b0;
            epc_reg          <= 32'd0;
            badvaddr_ena_reg <= 1'b0;
            badvaddr_reg     <= 32'd0;
            cls_exl_reg      <= 1'b0;
            redirect_pc_reg  <= 32'd0;
        end else begin
            update_ena_reg   <= exc_take;
            badvaddr_ena_reg <= exc_take & badvaddr_sel;
            cls_exl_reg      <= eret_take;
            if (exc_take) begin
                exccode_reg     <= exc_code;
                bd_reg          <= commit_in_ds;
                exl_reg         <= 1'b1;
                epc_reg         <= epc_val;
                redirect_pc_reg <= EXC_VEC;
            end
            if (exc_take & badvaddr_sel) begin
                badvaddr_reg <= badvaddr_val;
            end
            if (eret_take) begin
                redirect_pc_reg <= cp0_epc;
            end
        end
    end

    assign commit_ready       = (state_reg == ST_IDLE);
    assign flush              = (state_reg == ST_FLUSH);
    assign redirect_valid     = (state_reg == ST_REDIRECT);
    assign redirect_pc        = redirect_pc_reg;
    assign w_cp0_update_ena   = update_ena_reg;
    assign w_cp0_exccode      = exccode_reg;
    assign w_cp0_bd           = bd_reg;
    assign w_cp0_exl          = exl_reg;
    assign w_cp0_epc          = epc_reg;
    assign w_cp0_badvaddr_ena = badvaddr_ena_reg;
    assign w_cp0_badvaddr     = badvaddr_reg;
    assign cp0_cls_exl        = cls_exl_reg;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// ----------------------------------------------------------------------------
// tb_exc_commit_ctrl
//
// Directed testbench for exc_commit_ctrl using the default parameters
// (EXC_VEC = 0xBFC00380, FLUSH_CYCLES = 2). The expected values are written
// out by hand for each scenario.
// ----------------------------------------------------------------------------
module tb_exc_commit_ctrl;

    logic        clk;
    logic        rst;
    logic        commit_valid;
    logic        commit_ready;
    logic [31:0] commit_pc;
    logic        commit_in_ds;
    logic        commit_adel_if;
    logic        commit_ri;
    logic        commit_ov;
    logic        commit_syscall;
    logic        commit_break;
    logic        commit_adel_ld;
    logic        commit_ades;
    logic        commit_eret;
    logic [31:0] commit_mem_addr;
    logic        cp0_has_int;
    logic [31:0] cp0_epc;
    logic        w_cp0_update_ena;
    logic [4:0]  w_cp0_exccode;
    logic        w_cp0_bd;
    logic        w_cp0_exl;
    logic [31:0] w_cp0_epc;
    logic        w_cp0_badvaddr_ena;
    logic [31:0] w_cp0_badvaddr;
    logic        cp0_cls_exl;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int checks_reg = 0;
    int errors_reg = 0;
    int pulses;

    exc_commit_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .commit_valid       (commit_valid),
        .commit_ready       (commit_ready),
        .commit_pc          (commit_pc),
        .commit_in_ds       (commit_in_ds),
        .commit_adel_if     (commit_adel_if),
        .commit_ri          (commit_ri),
        .commit_ov          (commit_ov),
        .commit_syscall     (commit_syscall),
        .commit_break       (commit_break),
        .commit_adel_ld     (commit_adel_ld),
        .commit_ades        (commit_ades),
        .commit_eret        (commit_eret),
        .commit_mem_addr    (commit_mem_addr),
        .cp0_has_int        (cp0_has_int),
        .cp0_epc            (cp0_epc),
        .w_cp0_update_ena   (w_cp0_update_ena),
        .w_cp0_exccode      (w_cp0_exccode),
        .w_cp0_bd           (w_cp0_bd),
        .w_cp0_exl          (w_cp0_exl),
        .w_cp0_epc          (w_cp0_epc),
        .w_cp0_badvaddr_ena (w_cp0_badvaddr_ena),
        .w_cp0_badvaddr     (w_cp0_badvaddr),
        .cp0_cls_exl        (cp0_cls_exl),
        .flush              (flush),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .redirect_ready     (redirect_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_reg++;
        if (obs !== exp) begin
            errors_reg++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle away from that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        commit_valid    = 1'b0;
        commit_pc       = 32'd0;
        commit_in_ds    = 1'b0;
        commit_adel_if  = 1'b0;
        commit_ri       = 1'b0;
        commit_ov       = 1'b0;
        commit_syscall  = 1'b0;
        commit_break    = 1'b0;
        commit_adel_ld  = 1'b0;
        commit_ades     = 1'b0;
        commit_eret     = 1'b0;
        commit_mem_addr = 32'd0;
        cp0_has_int     = 1'b0;
    endtask

    // Step forward until redirect_valid is seen, within a bounded number of
    // cycles. Then accept the redirect and confirm the return to idle.
    task automatic finish_redirect(input string tag);
        int n = 0;
        while (!redirect_valid && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_redirect_seen"}, 32'(redirect_valid), 32'd1);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk({tag, "_idle_ready"}, 32'(commit_ready), 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_ready = 1'b0;
        cp0_epc        = 32'd0;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_commit_ready", 32'(commit_ready), 32'd1);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_update_ena", 32'(w_cp0_update_ena), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        $display("reset state checked");

        // Syscall, not in a delay slot
        commit_valid   = 1'b1;
        commit_syscall = 1'b1;
        commit_pc      = 32'hBFC00100;
        tick();
        clear_inputs();
        chk("sys_update_ena", 32'(w_cp0_update_ena), 32'd1);
        chk("sys_exccode", 32'(w_cp0_exccode), 32'h08);
        chk("sys_epc", w_cp0_epc, 32'hBFC00100);
        chk("sys_exl", 32'(w_cp0_exl), 32'd1);
        chk("sys_bd", 32'(w_cp0_bd), 32'd0);
        chk("sys_badvaddr_ena", 32'(w_cp0_badvaddr_ena), 32'd0);
        chk("sys_flush1", 32'(flush), 32'd1);
        chk("sys_commit_ready_busy", 32'(commit_ready), 32'd0);
        tick();
        chk("sys_flush2", 32'(flush), 32'd1);
        chk("sys_update_ena_off", 32'(w_cp0_update_ena), 32'd0);
        tick();
        chk("sys_flush_done", 32'(flush), 32'd0);
        chk("sys_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("sys_redirect_pc", redirect_pc, 32'hBFC00380);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("sys_commit_ready", 32'(commit_ready), 32'd1);
        chk("sys_redirect_dropped", 32'(redirect_valid), 32'd0);
        $display("syscall transaction done");

        // A commit with no flags must not trigger anything
        commit_valid = 1'b1;
        commit_pc    = 32'h00400000;
        tick();
        clear_inputs();
        chk("plain_update_ena", 32'(w_cp0_update_ena), 32'd0);
        chk("plain_flush", 32'(flush), 32'd0);
        chk("plain_ready", 32'(commit_ready), 32'd1);
        $display("plain commit transaction done");

        // Load address error in a delay slot
        commit_valid    = 1'b1;
        commit_adel_ld  = 1'b1;
        commit_in_ds    = 1'b1;
        commit_pc       = 32'h80000010;
        commit_mem_addr = 32'h80001003;
        tick();
        clear_inputs();
        chk("adel_exccode", 32'(w_cp0_exccode), 32'h04);
        chk("adel_bd", 32'(w_cp0_bd), 32'd1);
        chk("adel_epc", w_cp0_epc, 32'h8000000C);
        chk("adel_badvaddr_ena", 32'(w_cp0_badvaddr_ena), 32'd1);
        chk("adel_badvaddr", w_cp0_badvaddr, 32'h80001003);
        finish_redirect("adel");
        $display("load AdEL delay-slot transaction done");

        // An interrupt together with overflow: the interrupt wins, and only
        // one update pulse is produced
        pulses       = 0;
        commit_valid = 1'b1;
        cp0_has_int  = 1'b1;
        commit_ov    = 1'b1;
        commit_pc    = 32'h80000100;
        tick();
        clear_inputs();
        pulses += int'(w_cp0_update_ena);
        chk("int_exccode", 32'(w_cp0_exccode), 32'h00);
        chk("int_badvaddr_ena", 32'(w_cp0_badvaddr_ena), 32'd0);
        chk("int_badvaddr_hold", w_cp0_badvaddr, 32'h80001003);
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(w_cp0_update_ena);
        end
        chk("int_pulse_count", 32'(pulses), 32'd1);
        finish_redirect("int");
        $display("interrupt-over-overflow transaction done");

        // Fetch address error ranks above RI, and BadVAddr takes the PC
        commit_valid   = 1'b1;
        commit_adel_if = 1'b1;
        commit_ri      = 1'b1;
        commit_pc      = 32'h12345678;
        tick();
        clear_inputs();
        chk("adelif_exccode", 32'(w_cp0_exccode), 32'h04);
        chk("adelif_badvaddr", w_cp0_badvaddr, 32'h12345678);
        finish_redirect("adelif");
        $display("fetch AdEL transaction done");

        // Store address error ranks below Bp
        commit_valid    = 1'b1;
        commit_ades     = 1'b1;
        commit_mem_addr = 32'h00000002;
        tick();
        clear_inputs();
        chk("ades_exccode", 32'(w_cp0_exccode), 32'h05);
        chk("ades_badvaddr_ena", 32'(w_cp0_badvaddr_ena), 32'd1);
        finish_redirect("ades");
        commit_valid = 1'b1;
        commit_break = 1'b1;
        commit_ades  = 1'b1;
        tick();
        clear_inputs();
        chk("bp_exccode", 32'(w_cp0_exccode), 32'h09);
        chk("bp_badvaddr_ena", 32'(w_cp0_badvaddr_ena), 32'd0);
        finish_redirect("bp");
        $display("AdES and Bp transactions done");

        // ERET with a slow fetch
        commit_valid = 1'b1;
        commit_eret  = 1'b1;
        cp0_epc      = 32'hBFC00200;
        tick();
        clear_inputs();
        cp0_epc = 32'h0;
        chk("eret_cls_exl", 32'(cp0_cls_exl), 32'd1);
        chk("eret_update_ena", 32'(w_cp0_update_ena), 32'd0);
        tick();
        chk("eret_cls_exl_off", 32'(cp0_cls_exl), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("eret_hold_valid", 32'(redirect_valid), 32'd1);
            chk("eret_hold_pc", redirect_pc, 32'hBFC00200);
            tick();
        end
        chk("eret_still_valid", 32'(redirect_valid), 32'd1);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("eret_done_ready", 32'(commit_ready), 32'd1);
        $display("ERET transaction done");

        // Overflow in a delay slot at PC 0 (the EPC wraps). An RI commit
        // during the flush must be ignored.
        commit_valid = 1'b1;
        commit_ov    = 1'b1;
        commit_in_ds = 1'b1;
        commit_pc    = 32'h00000000;
        tick();
        clear_inputs();
        chk("wrap_epc", w_cp0_epc, 32'hFFFFFFFC);
        chk("wrap_exccode", 32'(w_cp0_exccode), 32'h0C);
        commit_valid = 1'b1;
        commit_ri    = 1'b1;
        tick();
        chk("busy_no_pulse", 32'(w_cp0_update_ena), 32'd0);
        chk("busy_exccode_hold", 32'(w_cp0_exccode), 32'h0C);
        clear_inputs();
        finish_redirect("wrap");
        $display("wrap and busy-ignore transaction done");

        // Reset while a redirect is pending
        commit_valid = 1'b1;
        commit_break = 1'b1;
        tick();
        clear_inputs();
        tick();
        tick();
        chk("rstred_pending", 32'(redirect_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstred_valid", 32'(redirect_valid), 32'd0);
        chk("rstred_flush", 32'(flush), 32'd0);
        chk("rstred_ready", 32'(commit_ready), 32'd1);
        $display("reset-during-redirect transaction done");

        $display("CHECKS %0d ERRORS %0d", checks_reg, errors_reg);
        $finish;
    end

endmodule
